// File: rtl/mult_div_seq.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) sequencer owning the HI/LO pair.
// Define MD_EARLY_EXIT_EN to finish zero-operand MULT/DIV in one cycle instead of WIDTH+1.
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_result,
    output logic [WIDTH-1:0] lo_result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, DZERO, DONE} stateType;

    stateType         state;
    logic [CW-1:0]    counter;
    logic [WIDTH:0]   multiplicand;
    logic [WIDTH:0]   accHigh;
    logic [WIDTH-1:0] accLow;
    logic             boothBit;
    logic             isDiv;
    logic             negQuot;
    logic             negRem;
    logic             zeroResult;

    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   boothSum;
    logic [WIDTH:0]   trialShift;
    logic [WIDTH:0]   trialDiff;
    logic [WIDTH-1:0] finalHi;
    logic [WIDTH-1:0] finalLo;
    logic             multSkip;
    logic             divSkip;

`ifdef MD_EARLY_EXIT_EN
    assign multSkip = (op_a == '0) || (op_b == '0);
    assign divSkip  = (op_a == '0);
`else
    assign multSkip = 1'b0;
    assign divSkip  = 1'b0;
`endif

    // Magnitudes of 0x80000000 stay 0x80000000, which is correct when read as unsigned.
    assign absA = op_a[WIDTH-1] ? -op_a : op_a;
    assign absB = op_b[WIDTH-1] ? -op_b : op_b;

    // One Booth add/sub and one restoring trial subtract; the high accumulator carries
    // an extra sign bit so that subtracting -2^(W-1) cannot overflow.
    always_comb begin
        boothSum = accHigh;
        case ({accLow[0], boothBit})
            2'b01:   boothSum = accHigh + multiplicand;
            2'b10:   boothSum = accHigh - multiplicand;
            default: boothSum = accHigh;
        endcase
        trialShift = {accHigh[WIDTH-1:0], accLow[WIDTH-1]};
        trialDiff  = trialShift - multiplicand;
    end

    always_comb begin
        finalHi = '0;
        finalLo = '0;
        if (!zeroResult) begin
            if (isDiv) begin
                finalHi = negRem  ? -accHigh[WIDTH-1:0] : accHigh[WIDTH-1:0];
                finalLo = negQuot ? -accLow : accLow;
            end else begin
                finalHi = accHigh[WIDTH-1:0];
                finalLo = accLow;
            end
        end
    end

    // The done pulse lands in the first IDLE cycle; busy is held through it so a start
    // arriving alongside done is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            counter      <= '0;
            multiplicand <= '0;
            accHigh      <= '0;
            accLow       <= '0;
            boothBit     <= 1'b0;
            isDiv        <= 1'b0;
            negQuot      <= 1'b0;
            negRem       <= 1'b0;
            zeroResult   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            div_zero     <= 1'b0;
            hi_result    <= '0;
            lo_result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (!done && mult_start) begin
                        multiplicand <= {op_a[WIDTH-1], op_a};
                        accHigh      <= '0;
                        accLow       <= op_b;
                        boothBit     <= 1'b0;
                        isDiv        <= 1'b0;
                        counter      <= '0;
                        busy         <= 1'b1;
                        zeroResult   <= multSkip;
                        state        <= multSkip ? DONE : MULT;
                    end else if (!done && div_start) begin
                        multiplicand <= {1'b0, absB};
                        accHigh      <= '0;
                        accLow       <= absA;
                        isDiv        <= 1'b1;
                        negQuot      <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                        negRem       <= op_a[WIDTH-1];
                        counter      <= '0;
                        busy         <= 1'b1;
                        zeroResult   <= divSkip;
                        if (op_b == '0) begin
                            state <= DZERO;
                        end else begin
                            state <= divSkip ? DONE : DIV;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                MULT: begin
                    accHigh  <= {boothSum[WIDTH], boothSum[WIDTH:1]};
                    accLow   <= {boothSum[0], accLow[WIDTH-1:1]};
                    boothBit <= accLow[0];
                    counter  <= counter + COUNT_ONE;
                    if (counter == LAST_COUNT) begin
                        state <= DONE;
                    end
                end
                DIV: begin
                    accHigh <= trialDiff[WIDTH] ? trialShift : trialDiff;
                    accLow  <= {accLow[WIDTH-2:0], ~trialDiff[WIDTH]};
                    counter <= counter + COUNT_ONE;
                    if (counter == LAST_COUNT) begin
                        state <= DONE;
                    end
                end
                DZERO: begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                    state    <= IDLE;
                end
                DONE: begin
                    done      <= 1'b1;
                    hi_result <= finalHi;
                    lo_result <= finalLo;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_seq.sv
// Directed bench for mult_div_seq: latency, MULT/DIV results, divide-by-zero, overflow,
// start arbitration, ignored starts, and asynchronous abort.
module tb_mult_div_seq;

    localparam int WIDTH = 32;

`ifdef MD_EARLY_EXIT_EN
    localparam int ZERO_LATENCY = 1;
`else
    localparam int ZERO_LATENCY = 33;
`endif

    logic             clock;
    logic             reset;
    logic             multStart;
    logic             divStart;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hiResult;
    logic [WIDTH-1:0] loResult;

    int vectors = 0;
    int miscompares = 0;
    int latency;
    int doneCount;
    logic startBusy;

    mult_div_seq #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .mult_start(multStart),
        .div_start (divStart),
        .op_a      (opA),
        .op_b      (opB),
        .busy      (busy),
        .done      (done),
        .div_zero  (divZero),
        .hi_result (hiResult),
        .lo_result (loResult)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison funnels through here so the counts stay in one place.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Issues a one-cycle start, then waits (bounded) for done; cycles is -1 on timeout.
    task automatic applyStimulus(input logic doMult, input logic doDiv, input logic [31:0] a,
                                 input logic [31:0] b, output int cycles, output logic busyAfter);
        multStart = doMult;
        divStart  = doDiv;
        opA       = a;
        opB       = b;
        @(posedge clock); #1;
        multStart = 1'b0;
        divStart  = 1'b0;
        busyAfter = busy;
        cycles    = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clock); #1;
            if (done) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic watchNoDone(input int n, output int count);
        count = 0;
        repeat (n) begin
            @(posedge clock); #1;
            if (done) count++;
        end
    endtask

    initial begin
        reset     = 1'b1;
        multStart = 1'b0;
        divStart  = 1'b0;
        opA       = '0;
        opB       = '0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("resetBusy", {31'b0, busy}, 32'd0);
        checkOutput("resetDone", {31'b0, done}, 32'd0);
        checkOutput("resetDivZero", {31'b0, divZero}, 32'd0);
        checkOutput("resetHi", hiResult, 32'h0);
        checkOutput("resetLo", loResult, 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;

        // 7 * -3
        applyStimulus(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, latency, startBusy);
        checkOutput("mult1Busy", {31'b0, startBusy}, 32'd1);
        checkOutput("mult1Latency", latency, 32'd33);
        checkOutput("mult1Hi", hiResult, 32'hFFFF_FFFF);
        checkOutput("mult1Lo", loResult, 32'hFFFF_FFEB);
        checkOutput("mult1DivZero", {31'b0, divZero}, 32'd0);
        @(posedge clock); #1;
        checkOutput("mult1DonePulse", {31'b0, done}, 32'd0);
        checkOutput("mult1BusyClear", {31'b0, busy}, 32'd0);

        // -7 / 2
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, latency, startBusy);
        checkOutput("div1Latency", latency, 32'd33);
        checkOutput("div1Lo", loResult, 32'hFFFF_FFFD);
        checkOutput("div1Hi", hiResult, 32'hFFFF_FFFF);
        @(posedge clock); #1;

        // 0x451 / 0x20 leaves hi=0x11, lo=0x22 before the divide-by-zero
        applyStimulus(1'b0, 1'b1, 32'h451, 32'h20, latency, startBusy);
        checkOutput("divPrepLo", loResult, 32'h22);
        checkOutput("divPrepHi", hiResult, 32'h11);
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd0, latency, startBusy);
        checkOutput("dzLatency", latency, 32'd1);
        checkOutput("dzFlag", {31'b0, divZero}, 32'd1);
        checkOutput("dzHi", hiResult, 32'h11);
        checkOutput("dzLo", loResult, 32'h22);
        @(posedge clock); #1;
        checkOutput("dzFlagPulse", {31'b0, divZero}, 32'd0);

        // Most-negative operands
        applyStimulus(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, latency, startBusy);
        checkOutput("multMinHi", hiResult, 32'h4000_0000);
        checkOutput("multMinLo", loResult, 32'h0);
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, latency, startBusy);
        checkOutput("divOvfLatency", latency, 32'd33);
        checkOutput("divOvfLo", loResult, 32'h8000_0000);
        checkOutput("divOvfHi", hiResult, 32'h0);
        checkOutput("divOvfDivZero", {31'b0, divZero}, 32'd0);
        @(posedge clock); #1;

        // Both starts together; a div_start mid-op and on the done cycle must be dropped
        multStart = 1'b1;
        divStart  = 1'b1;
        opA       = 32'd6;
        opB       = 32'd3;
        @(posedge clock); #1;
        multStart = 1'b0;
        divStart  = 1'b0;
        latency   = -1;
        for (int k = 1; k <= 100; k++) begin
            if (k == 5) begin
                checkOutput("midOpLoHeld", loResult, 32'h8000_0000);
                divStart = 1'b1;
                opA      = 32'd100;
                opB      = 32'd7;
            end else begin
                divStart = 1'b0;
            end
            @(posedge clock); #1;
            if (done) begin
                latency = k;
                break;
            end
        end
        divStart = 1'b0;
        checkOutput("bothLatency", latency, 32'd33);
        checkOutput("bothHi", hiResult, 32'h0);
        checkOutput("bothLo", loResult, 32'd18);
        divStart = 1'b1;
        @(posedge clock); #1;
        divStart = 1'b0;
        checkOutput("doneCycleStartBusy", {31'b0, busy}, 32'd0);
        watchNoDone(40, doneCount);
        checkOutput("ignoredStartsNoDone", doneCount, 32'd0);

        // Asynchronous abort partway through a MULT
        multStart = 1'b1;
        opA       = 32'd5;
        opB       = 32'd7;
        @(posedge clock); #1;
        multStart = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abortBusy", {31'b0, busy}, 32'd0);
        checkOutput("abortHi", hiResult, 32'h0);
        checkOutput("abortLo", loResult, 32'h0);
        checkOutput("abortDone", {31'b0, done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        watchNoDone(40, doneCount);
        checkOutput("abortNoDone", doneCount, 32'd0);

        // Zero operand: early exit when enabled, full latency otherwise
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd7, latency, startBusy);
        checkOutput("multPrepLo", loResult, 32'd35);
        @(posedge clock); #1;
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd9, latency, startBusy);
        checkOutput("zeroMultLatency", latency, ZERO_LATENCY);
        checkOutput("zeroMultLo", loResult, 32'h0);
        checkOutput("zeroMultHi", hiResult, 32'h0);
        @(posedge clock); #1;
        applyStimulus(1'b0, 1'b1, 32'd0, 32'hFFFF_FFFB, latency, startBusy);
        checkOutput("zeroDivLatency", latency, ZERO_LATENCY);
        checkOutput("zeroDivLo", loResult, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
